uart_out_linebuf: RTL and testbench
===================================

# uart_out_linebuf

Line-assembling buffer between SimTop's UART output (`io_uart_out_valid` / `io_uart_out_ch`) and the simulation-top character printer. It captures every character the DUT emits and holds it until a complete line exists. It then releases the line over a valid/ready stream, so the printer flushes whole lines instead of single characters. Lines are also released when the buffer fills or the DUT goes quiet.

## Interface
Parameters:
- `DEPTH`, 64: FIFO entries; must be a power of two, at least 4.
- `IDLE_FLUSH`, 1024: number of idle cycles with uncommitted characters before a forced commit; at least 2.

Ports:
- `clock`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: a DUT character is present this cycle. There is no backpressure.
- `in_ch`, input, 8: DUT character.
- `out_valid`, output, 1: a committed character is available.
- `out_ch`, output, 8: committed character; 8'h00 whenever `out_valid`=0.
- `out_last`, output, 1: this character closes a committed chunk; 0 whenever `out_valid`=0.
- `out_ready`, input, 1: the printer accepts the character.
- `drop_cnt`, output, 32: characters dropped because the FIFO was full; saturates at 32'hFFFF_FFFF.
- `line_cnt`, output, 32: number of chunks committed; wraps modulo 2^32.

## Operation
- Storage is a DEPTH x 9 array holding {last, ch}, managed by three pointers of log2(DEPTH)+1 bits each:
  - `wr_ptr` advances on each accepted write.
  - `cm_ptr` is the commit boundary.
  - `rd_ptr` advances on each output handshake.
- `count` = `wr_ptr` - `rd_ptr`. `full` = (`count` == DEPTH). `pending` = (`wr_ptr` != `cm_ptr`).
- Write: when `in_valid` and not `full` (evaluated before this cycle's read), write {last, `in_ch`} at `wr_ptr` and increment `wr_ptr`.
  - If `in_valid` and `full`, the character is dropped and `drop_cnt` increments. This holds even if a read happens in the same cycle.
- Commit: sets `cm_ptr` to the new `wr_ptr`, sets the last bit on the newest entry, and increments `line_cnt`. A commit is triggered by any of:
  - a written character equal to 8'h0A (newline), with last=1 written directly;
  - a write that makes `count` reach DEPTH;
  - the idle timer expiring.
- Idle timer, a small state machine:
  - EMPTY: no pending characters; timer held at 0.
  - COLLECT: pending characters exist. The timer clears on every accepted write and otherwise increments.
  - When the timer reaches IDLE_FLUSH-1 in COLLECT, the block commits (the last bit is written into entry `wr_ptr`-1) and returns to EMPTY.
  - A newline or full commit also returns the state machine to EMPTY.
  - A write without a commit moves it from EMPTY to COLLECT.
- Output: `out_valid` = (`rd_ptr` != `cm_ptr`). `out_ch` and `out_last` are read combinationally from entry `rd_ptr`.
  - A handshake (`out_valid` and `out_ready`) increments `rd_ptr`.
  - `out_ch` and `out_last` are stable while `out_valid` is high and no handshake has occurred.
- Pointers wrap naturally; the index is the low log2(DEPTH) bits.

## Timing
- Reset (`reset`=0 at a clock edge): all pointers, the timer, `drop_cnt` and `line_cnt` go to 0 and the state goes to EMPTY. `out_valid`, `out_ch` and `out_last` are 0 in the following cycle.
  - Reset mid-operation discards all buffered data with no partial output.
  - An `in_valid` during reset is ignored and not counted as dropped.
- Latency: a newline written at edge N makes `out_valid`=1 in cycle N+1, with the first character of the line at `out_ch`.
- Throughput: one write and one read per cycle, simultaneously.
- Idle commit: last write at edge N with no further writes gives `out_valid`=1 after edge N+IDLE_FLUSH.
- Simultaneous newline and idle expiry: the newline commit wins; `line_cnt` increments by 1.
- Simultaneous full commit and newline on the same write: `line_cnt` increments by 1.

## Configuration
- `UART_LINEBUF_CR_STRIP_EN`
  - Defined: an input of 8'h0D is discarded before the write check. It is never stored, never counted in `drop_cnt`, and does not clear the idle timer.
  - Undefined: 8'h0D is stored like any other character.

## Test plan
- Write "hi\n" (8'h68, 8'h69, 8'h0A) on consecutive cycles with `out_ready`=1 -> three characters out in order, `out_last`=1 only on 8'h0A, `line_cnt`=1.
- Write "abc" with no newline and IDLE_FLUSH=16 -> `out_valid` stays 0 for 15 idle cycles, rises after the 16th, and 8'h63 carries `out_last`=1.
- DEPTH=8, `out_ready`=0, write 10 non-newline characters -> 8 stored and committed with last on the 8th, `drop_cnt`=2, `line_cnt`=1.
- Hold `out_ready`=0 for 5 cycles with a committed line -> `out_ch` is held stable; releasing `out_ready` drains the line with no duplicates.
- Write "ab", assert `reset`=0 for one cycle, then write "c\n" -> output is only 8'h63, 8'h0A, and all counters are 1 or 0 accordingly.
- With `UART_LINEBUF_CR_STRIP_EN`, write "x\r\n" -> output is 8'h78, 8'h0A. Without the macro -> output is 8'h78, 8'h0D, 8'h0A.

Source files
------------

// File: rtl/uart_out_linebuf.sv
// uart_out_linebuf
//
// Line-assembling buffer between the DUT UART output and the simulation-top
// character printer. Characters are collected in a FIFO and only become
// visible on the output stream once a chunk is committed. A chunk is
// committed by a newline, by the FIFO filling up, or by the DUT staying
// quiet for IDLE_FLUSH cycles while uncommitted characters are held.
//
// Parameters:
//   DEPTH      - FIFO entries, power of two, >= 4
//   IDLE_FLUSH - idle cycles with pending characters before a forced commit, >= 2
//
// Ports:
//   clock     - clock
//   reset     - synchronous, active-low reset
//   in_valid  - DUT character present this cycle (no backpressure)
//   in_ch     - DUT character
//   out_valid - a committed character is available
//   out_ch    - committed character, 8'h00 when out_valid is low
//   out_last  - character closes a committed chunk, 0 when out_valid is low
//   out_ready - printer accepts the character
//   drop_cnt  - characters dropped on a full FIFO, saturating
//   line_cnt  - chunks committed, wrapping
//
// Build option:
//   UART_LINEBUF_CR_STRIP_EN - when defined, 8'h0D is discarded on input
//   (never stored, never counted as dropped, does not restart the idle timer).

module uart_out_linebuf #(
    parameter int DEPTH      = 64,
    parameter int IDLE_FLUSH = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_ch,
    output logic        out_valid,
    output logic [7:0]  out_ch,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] drop_cnt,
    output logic [31:0] line_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(IDLE_FLUSH) + 1;

    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0] DEPTH_M1  = PW'(DEPTH - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_FLUSH - 1);

    typedef enum logic {
        ST_EMPTY,
        ST_COLLECT
    } idle_state_t;

    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] prev_idx;

    idle_state_t   state;
    idle_state_t   state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    logic ch_accept;
    logic full;
    logic wr_en;
    logic drop;
    logic rd_en;
    logic nl_commit;
    logic full_commit;
    logic idle_expire;
    logic commit;
    logic idle_mark;
    logic [8:0] head;

`ifdef UART_LINEBUF_CR_STRIP_EN
    assign ch_accept = in_valid && (in_ch != 8'h0D);
`else
    assign ch_accept = in_valid;
`endif

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == DEPTH_P);
    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign prev_idx = wr_idx - AW'(1);

    // Full is judged on the pre-read occupancy, so a same-cycle read does
    // not rescue a character arriving at a full FIFO.
    assign wr_en = ch_accept && !full;
    assign drop  = ch_accept && full;
    assign rd_en = out_valid && out_ready;

    assign nl_commit   = wr_en && (in_ch == 8'h0A);
    assign full_commit = wr_en && (count == DEPTH_M1);
    assign idle_expire = (state == ST_COLLECT) && (timer == TIMER_MAX);
    assign commit      = nl_commit || full_commit || idle_expire;

    // An expiry coinciding with a write closes the chunk on the new entry;
    // otherwise the last bit is patched into the newest stored entry.
    assign idle_mark = idle_expire && !wr_en;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_EMPTY;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        if (commit) begin
            state_next = ST_EMPTY;
            timer_next = '0;
        end else if (wr_en) begin
            state_next = ST_COLLECT;
            timer_next = '0;
        end else if (state == ST_COLLECT) begin
            timer_next = timer + TW'(1);
        end else begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            line_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                cm_ptr   <= wr_en ? (wr_ptr + PW'(1)) : wr_ptr;
                line_cnt <= line_cnt + 32'd1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    // Storage carries no reset; visibility is governed purely by the pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (wr_en) begin
                mem[wr_idx] <= {commit, in_ch};
            end else if (idle_mark) begin
                mem[prev_idx][8] <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_idx];
    assign out_valid = (rd_ptr != cm_ptr);
    assign out_ch    = out_valid ? head[7:0] : 8'h00;
    assign out_last  = out_valid ? head[8] : 1'b0;

endmodule

// File: tb/tb_uart_out_linebuf.sv
// tb_uart_out_linebuf
//
// Self-checking bench for uart_out_linebuf (DEPTH=8, IDLE_FLUSH=16).
// A queue-based reference model tracks stored characters, the committed
// prefix, drops and chunk count; a negedge process compares every output
// against it each cycle. Directed scenarios also check literal values.
// Honours UART_LINEBUF_CR_STRIP_EN for the carriage-return scenario.

module tb_uart_out_linebuf;

    localparam int DEPTH = 8;
    localparam int IDLE  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ch = 8'h00;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        out_last;
    logic [31:0] drop_cnt;
    logic [31:0] line_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [8:0]  mq[$];
    int          ncom = 0;
    logic [31:0] m_drop = 32'd0;
    logic [31:0] m_lines = 32'd0;
    int          edge_no = 0;
    int          last_wr = 0;
    bit          model_live = 1'b0;

    // Handshaked output stream, {last, ch}
    logic [8:0]  got[$];

    uart_out_linebuf #(
        .DEPTH(DEPTH),
        .IDLE_FLUSH(IDLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ch(in_ch),
        .out_valid(out_valid),
        .out_ch(out_ch),
        .out_last(out_last),
        .out_ready(out_ready),
        .drop_cnt(drop_cnt),
        .line_cnt(line_cnt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic v, input logic [7:0] ch, input logic rdy);
        reset     = rst_n;
        in_valid  = v;
        in_ch     = ch;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic expectNext(input string name, input logic [8:0] exp);
        if (got.size() > 0)
            checkOutput(name, 32'(got.pop_front()), 32'(exp));
        else
            checkOutput(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, rdy);
    endtask

    // Reference model: a chunk becomes visible when a newline is stored, when
    // a store brings occupancy to DEPTH, or IDLE edges after the last store
    // while stored characters are still uncommitted.
    always @(posedge clock) begin : model_step
        bit acc;
        bit do_read;
        bit was_full;
        bit pend;
        bit expire;
        bit cm;
        int pre_size;
        logic [8:0] tmp;
        edge_no++;
        if (!reset) begin
            mq.delete();
            ncom = 0;
            m_drop = 32'd0;
            m_lines = 32'd0;
            model_live = 1'b1;
        end else begin
            acc = in_valid;
`ifdef UART_LINEBUF_CR_STRIP_EN
            if (in_ch == 8'h0D) acc = 1'b0;
`endif
            pre_size = mq.size();
            was_full = (pre_size == DEPTH);
            do_read  = (ncom > 0) && out_ready;
            pend     = (ncom < pre_size);
            expire   = pend && ((edge_no - last_wr) == IDLE);
            cm = 1'b0;
            if (do_read) begin
                void'(mq.pop_front());
                ncom--;
            end
            if (acc && was_full) begin
                if (m_drop != 32'hFFFF_FFFF) m_drop++;
                cm = expire;
            end else if (acc) begin
                mq.push_back({1'b0, in_ch});
                last_wr = edge_no;
                cm = (in_ch == 8'h0A) || (pre_size + 1 == DEPTH) || expire;
            end else begin
                cm = expire;
            end
            if (cm) begin
                tmp = mq[mq.size() - 1];
                tmp[8] = 1'b1;
                mq[mq.size() - 1] = tmp;
                ncom = mq.size();
                m_lines++;
            end
        end
    end

    // Cycle-by-cycle comparison and output capture
    always @(negedge clock) begin : compare
        logic [8:0] head;
        if (model_live) begin
            head = (ncom > 0) ? mq[0] : 9'h000;
            checkOutput("out_valid", 32'(out_valid), 32'(ncom > 0));
            checkOutput("out_ch", 32'(out_ch), 32'(head[7:0]));
            checkOutput("out_last", 32'(out_last), 32'(head[8]));
            checkOutput("drop_cnt", drop_cnt, m_drop);
            checkOutput("line_cnt", line_cnt, m_lines);
            if (reset && out_valid && out_ready) got.push_back({out_last, out_ch});
        end
    end

    initial begin
        // Reset with a character present: ignored, not dropped
        applyStimulus(1'b0, 1'b1, 8'h7A, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h7A, 1'b1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ch", 32'(out_ch), 32'd0);
        checkOutput("rst_drop", drop_cnt, 32'd0);
        checkOutput("rst_line", line_cnt, 32'd0);

        // "hi\n"
        applyStimulus(1'b1, 1'b1, 8'h68, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h69, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        checkOutput("nl_latency_valid", 32'(out_valid), 32'd1);
        checkOutput("nl_latency_ch", 32'(out_ch), 32'h68);
        idleCycles(4, 1'b1);
        expectNext("hi_0", 9'h068);
        expectNext("hi_1", 9'h069);
        expectNext("hi_2", 9'h10A);
        checkOutput("hi_lines", line_cnt, 32'd1);

        // "abc" then idle flush
        applyStimulus(1'b1, 1'b1, 8'h61, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h62, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h63, 1'b1);
        for (int i = 0; i < IDLE - 1; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
            checkOutput("idle_hold", 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("idle_rise", 32'(out_valid), 32'd1);
        checkOutput("idle_first", 32'(out_ch), 32'h61);
        idleCycles(4, 1'b1);
        expectNext("abc_0", 9'h061);
        expectNext("abc_1", 9'h062);
        expectNext("abc_2", 9'h163);
        checkOutput("abc_lines", line_cnt, 32'd2);

        // Fill to DEPTH with the printer stalled; two characters dropped
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'h41 + 8'(i), 1'b0);
        checkOutput("fill_drop", drop_cnt, 32'd2);
        checkOutput("fill_lines", line_cnt, 32'd3);
        checkOutput("fill_valid", 32'(out_valid), 32'd1);
        checkOutput("fill_last0", 32'(out_last), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
            checkOutput("stall_ch", 32'(out_ch), 32'h41);
        end
        idleCycles(8, 1'b1);
        checkOutput("fill_drained", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) expectNext("fill_seq", {(i == 7), 8'h41 + 8'(i)});
        checkOutput("fill_nodup", 32'(got.size()), 32'd0);

        // Reset in the middle of an uncommitted line
        applyStimulus(1'b1, 1'b1, 8'h61, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h62, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h71, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h63, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        idleCycles(3, 1'b1);
        expectNext("rst_mid_0", 9'h063);
        expectNext("rst_mid_1", 9'h10A);
        checkOutput("rst_mid_nodup", 32'(got.size()), 32'd0);
        checkOutput("rst_mid_lines", line_cnt, 32'd1);
        checkOutput("rst_mid_drop", drop_cnt, 32'd0);

        // "x\r\n"
        applyStimulus(1'b1, 1'b1, 8'h78, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0D, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        idleCycles(4, 1'b1);
        expectNext("cr_0", 9'h078);
`ifndef UART_LINEBUF_CR_STRIP_EN
        expectNext("cr_1", 9'h00D);
`endif
        expectNext("cr_nl", 9'h10A);
        checkOutput("cr_lines", line_cnt, 32'd2);

        // Newline arriving exactly on idle expiry: a single commit
        applyStimulus(1'b1, 1'b1, 8'h75, 1'b1);
        idleCycles(IDLE - 1, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        idleCycles(3, 1'b1);
        expectNext("race_0", 9'h075);
        expectNext("race_1", 9'h10A);
        checkOutput("race_lines", line_cnt, 32'd3);

        // Back-to-back lines with simultaneous read and write
        applyStimulus(1'b1, 1'b1, 8'h70, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h71, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h72, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h73, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b1);
        idleCycles(6, 1'b1);
        expectNext("b2b_0", 9'h070);
        expectNext("b2b_1", 9'h071);
        expectNext("b2b_2", 9'h10A);
        expectNext("b2b_3", 9'h072);
        expectNext("b2b_4", 9'h073);
        expectNext("b2b_5", 9'h10A);
        checkOutput("b2b_lines", line_cnt, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
